// File: rtl/fp_result_fifo.sv
// Result FIFO between the FP add/sub datapath and its consumer.
// First-word fall-through head, saturating exception/zero statistics.
module fp_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_exception,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [STAT_W-1:0]          exc_count,
  output logic [STAT_W-1:0]          zero_count,
  input  logic                       clr_stats
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0] mem_result [DEPTH];
  logic [1:0]  mem_flag   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;

  logic push;
  logic pop;
  logic exc_hit;
  logic zero_hit;

  // Ready comes from registered occupancy only; no path from out_ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign exc_hit  = push && in_exception;
  assign zero_hit = push && in_zero && !in_exception;

  assign wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_flag[wr_ptr]   <= {in_exception, in_zero};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_count <= '0;
    end else if (clr_stats) begin
      exc_count <= '0;
    end else if (exc_hit && (exc_count != '1)) begin
      exc_count <= exc_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_count <= '0;
    end else if (clr_stats) begin
      zero_count <= '0;
    end else if (zero_hit && (zero_count != '1)) begin
      zero_count <= zero_count + 1'b1;
    end
  end

  always_comb begin
    out_result = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_result = mem_result[rd_ptr];
      out_flags  = {mem_flag[rd_ptr], mem_result[rd_ptr][31]};
    end
  end

endmodule

// File: doc/fp_result_fifo.md
FP_RESULT_FIFO -- requirements
Module: fp_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter STAT_W, default 8, meaning width of the saturating statistics counters.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid  input  1  producer offers a result from the add/sub datapath this cycle.
REQ-006 The block SHALL have port in_ready  output  1  FIFO can accept; equals (count != DEPTH).
REQ-007 The block SHALL have port in_result  input  32  IEEE-754 single result word from add/sub.
REQ-008 The block SHALL have port in_exception  input  1  add/sub Exception flag (an operand exponent was all ones).
REQ-009 The block SHALL have port in_zero  input  1  add/sub zero flag.
REQ-010 The block SHALL have port out_valid  output  1  head entry available; equals (count != 0).
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-012 The block SHALL have port out_result  output  32  head result word (first-word fall-through).
REQ-013 The block SHALL have port out_flags  output  3  head flags {exception, zero, sign}; sign = stored in_result[31].
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 The block SHALL have port exc_count  output  STAT_W  number of accepted entries with exception=1, saturating.
REQ-016 The block SHALL have port zero_count  output  STAT_W  number of accepted entries with zero=1 and exception=0, saturating.
REQ-017 The block SHALL have port clr_stats  input  1  synchronous clear of exc_count and zero_count.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-020 A pushed entry SHALL be visible on out_* the cycle after the push edge (latency 1, empty-to-valid).
REQ-021 out_result/out_flags SHALL be driven from the rd_ptr entry combinationally; when out_valid=0 they SHALL be 0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count==DEPTH? no: when full, in_ready=0, so no push; the pop frees one slot only on the following cycle.
REQ-023 Simultaneous push and pop with count==0 SHALL not occur (out_valid=0); the push lands and count becomes 1.
REQ-024 in_ready SHALL depend only on registered count, never on out_ready (no combinational ready path).
REQ-025 Data on in_* while in_valid=0 or in_ready=0 SHALL be ignored and SHALL not alter any state.
REQ-026 exc_count SHALL increment on each push with in_exception=1; zero_count on each push with in_zero=1 and in_exception=0; each SHALL hold at 2^STAT_W-1.
REQ-027 clr_stats=1 SHALL zero both counters at the edge, overriding any same-cycle increment.
REQ-028 An entry with in_exception=1 SHALL be stored exactly as received (expected word 32'hFFFFFFFF), no substitution.

Reset
REQ-029 While rst_n=0: wr_ptr, rd_ptr, count, exc_count, zero_count SHALL be 0; in_ready=1, out_valid=0, out_result=0, out_flags=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries immediately; storage array contents need not be cleared.
REQ-031 First push SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-032 Reset, push 32'h40400000 (flags 0) with out_ready=0 -> next cycle out_valid=1, out_result=32'h40400000, out_flags=3'b000, count=1.
REQ-033 Push 4 entries, out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; then pop all -> order preserved, count=0, out_valid=0.
REQ-034 Hold count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap, output order equals input order.
REQ-035 Push 32'hFFFFFFFF exc=1, 32'h00000000 zero=1, 32'hC0000000 -> out_flags 3'b101, 3'b010, 3'b001; exc_count=1, zero_count=1.
REQ-036 STAT_W=8, 300 exception pushes, drained continuously -> exc_count=255; clr_stats with a concurrent exception push -> exc_count=0.
REQ-037 With count=3, drop rst_n for half a cycle asynchronously -> out_valid=0, count=0 without waiting for clk; after release, new push appears intact.
